// File: rtl/game_pkg.sv
// Shared definitions for the 2048 move engine.
//   W, N, SHIFT_MAX : tile width, board side, gravity step limit per phase
//   board_t         : board[row][col], each cell a W-bit tile value (0 = empty)
//   DIR_*           : one-hot move directions
//   state_t         : move_compactor sequencer states
package game_pkg;

  localparam int W         = 12;
  localparam int N         = 4;
  localparam int SHIFT_MAX = 3;

  typedef logic [N-1:0][N-1:0][W-1:0] board_t;

  localparam logic [3:0] DIR_LEFT  = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT1,
    ST_SUM,
    ST_SHIFT2,
    ST_DONE
  } state_t;

endpackage

// File: rtl/board_rotate.sv
// Combinational board rotation between the natural frame and the work frame,
// in which the move direction always points toward row 0.
//   dir       in  4        one-hot move direction (non-one-hot passes through)
//   inverse   in  1        0: natural -> work frame, 1: work -> natural frame
//   board_in  in  board_t  source board
//   board_out out board_t  rotated board
module board_rotate
  import game_pkg::*;
(
  input  logic [3:0] dir,
  input  logic       inverse,
  input  board_t     board_in,
  output board_t     board_out
);

  always_comb begin
    board_out = board_in;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!inverse) begin
          if (dir == DIR_LEFT)       board_out[i][j] = board_in[j][N-1-i];
          else if (dir == DIR_UP)    board_out[i][j] = board_in[N-1-i][j];
          else if (dir == DIR_RIGHT) board_out[i][j] = board_in[N-1-j][i];
        end else begin
          if (dir == DIR_LEFT)       board_out[i][j] = board_in[N-1-j][i];
          else if (dir == DIR_UP)    board_out[i][j] = board_in[N-1-i][j];
          else if (dir == DIR_RIGHT) board_out[i][j] = board_in[j][N-1-i];
        end
      end
    end
  end

endmodule

// File: rtl/move_compactor.sv
// Sequential 2048 move engine: compacts the board toward the move direction,
// hands it to the external summation stage, optionally compacts once more,
// and returns the final board with a moved flag.
//   clk, rst_n   clock, asynchronous active-low reset
//   move_valid   move request; accepted only in IDLE with a one-hot direction
//   move_ready   high in IDLE
//   direction    one-hot move direction
//   board_i      current board (natural frame), sampled on accept
//   sum_dir_o    latched direction to summation
//   sum_board_o  compacted board to summation (meaningful in SUM only)
//   summed_i     combinational summation result (natural frame)
//   sum_ready_i  summation flag, 0 = gaps remain after merging
//   board_o      final board, valid with done
//   done         one-cycle completion pulse
//   moved        board_o differs from the sampled board; held until next accept
module move_compactor
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [3:0] direction,
  input  board_t     board_i,
  output logic [3:0] sum_dir_o,
  output board_t     sum_board_o,
  input  board_t     summed_i,
  input  logic       sum_ready_i,
  output board_t     board_o,
  output logic       done,
  output logic       moved
);

  state_t         state, state_next;
  board_t         work, work_next;
  board_t         orig;          // sampled board, kept in the work frame
  board_t         fwd_in, fwd_out, grav;
  logic [3:0]     dir_reg, fwd_dir;
  logic [1:0]     step_cnt, step_cnt_next;
  logic           moved_reg, accept, settled;
  logic [N*N-1:0] unsettled;

  assign accept = (state == ST_IDLE) && move_valid && $onehot(direction);

  // One forward rotator serves both the accept sample and the summation capture.
  assign fwd_dir = (state == ST_IDLE) ? direction : dir_reg;
  assign fwd_in  = (state == ST_SUM) ? summed_i : board_i;

  board_rotate u_fwd (
    .dir      (fwd_dir),
    .inverse  (1'b0),
    .board_in (fwd_in),
    .board_out(fwd_out)
  );

  board_rotate u_inv (
    .dir      (dir_reg),
    .inverse  (1'b1),
    .board_in (work),
    .board_out(board_o)
  );

  assign sum_board_o = board_o;
  assign sum_dir_o   = dir_reg;
  assign move_ready  = (state == ST_IDLE);
  assign done        = (state == ST_DONE);
  // During DONE the flag is live; afterwards the registered copy holds it.
  assign moved       = (state == ST_DONE) ? (work != orig) : moved_reg;

  // One parallel gravity step in the work frame: a tile falls one row when
  // the cell below it was empty at the start of the cycle.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic         below_empty;
      logic [W-1:0] above;
      if (gi == 0) begin : g_front
        assign below_empty = 1'b0;
      end else begin : g_inner
        assign below_empty = (work[gi-1][gj] == '0);
      end
      if (gi == N-1) begin : g_back
        assign above = '0;
      end else begin : g_feed
        assign above = work[gi+1][gj];
      end
      // An empty cell takes whatever sits above it (the tile above is free to fall).
      assign grav[gi][gj]          = (work[gi][gj] == '0) ? above
                                   : (below_empty ? '0 : work[gi][gj]);
      assign unsettled[gi*N + gj]  = (work[gi][gj] != '0) && below_empty;
    end
  end

  assign settled = ~|unsettled;

  always_comb begin
    state_next    = state;
    work_next     = work;
    step_cnt_next = step_cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next    = ST_SHIFT1;
          work_next     = fwd_out;
          step_cnt_next = '0;
        end
      end
      ST_SHIFT1, ST_SHIFT2: begin
        if (settled || step_cnt == 2'(SHIFT_MAX)) begin
          state_next    = (state == ST_SHIFT1) ? ST_SUM : ST_DONE;
          step_cnt_next = '0;
        end else begin
          work_next     = grav;
          step_cnt_next = step_cnt + 2'd1;
        end
      end
      ST_SUM: begin
        work_next  = fwd_out;
        state_next = sum_ready_i ? ST_DONE : ST_SHIFT2;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      work      <= '0;
      orig      <= '0;
      dir_reg   <= '0;
      step_cnt  <= '0;
      moved_reg <= 1'b0;
    end else begin
      state    <= state_next;
      work     <= work_next;
      step_cnt <= step_cnt_next;
      if (accept) begin
        dir_reg   <= direction;
        orig      <= fwd_out;
        moved_reg <= 1'b0;
      end else if (state == ST_DONE) begin
        moved_reg <= (work != orig);
      end
    end
  end

endmodule

// File: tb/tb_move_compactor.sv
// Self-checking bench for move_compactor: directed moves followed by random
// moves, checked against a line-oriented reference of the 2048 move rules.
module tb_move_compactor;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       move_valid = 1'b0;
  logic       move_ready;
  logic [3:0] direction = '0;
  board_t     board_i = '0;
  logic [3:0] sum_dir_o;
  board_t     sum_board_o;
  board_t     summed_i;
  logic       sum_ready_i;
  board_t     board_o;
  logic       done;
  logic       moved;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  move_compactor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .direction  (direction),
    .board_i    (board_i),
    .sum_dir_o  (sum_dir_o),
    .sum_board_o(sum_board_o),
    .summed_i   (summed_i),
    .sum_ready_i(sum_ready_i),
    .board_o    (board_o),
    .done       (done),
    .moved      (moved)
  );

  // Cell of line k at position p, p=0 being the cell the move pushes toward.
  function automatic void line_coord(input logic [3:0] d, input int k, input int p,
                                     output int r, output int c);
    case (d)
      DIR_LEFT: begin r = k;     c = N-1-p; end
      DIR_DOWN: begin r = p;     c = k;     end
      DIR_UP:   begin r = N-1-p; c = k;     end
      default:  begin r = k;     c = p;     end
    endcase
  endfunction

  // Summation stage model: merge equal neighbours front-first, each tile at
  // most once; rdy=0 when any line is left with a gap in front of a tile.
  function automatic board_t sum_model(input board_t b, input logic [3:0] d, output bit rdy);
    board_t       o;
    logic [W-1:0] v[N];
    int           r, c, p;
    bit           gap;
    o   = b;
    rdy = 1'b1;
    for (int k = 0; k < N; k++) begin
      for (int q = 0; q < N; q++) begin
        line_coord(d, k, q, r, c);
        v[q] = b[r][c];
      end
      p = 0;
      while (p < N-1) begin
        if (v[p] != '0 && v[p] == v[p+1]) begin
          v[p]   = v[p] << 1;
          v[p+1] = '0;
          p += 2;
        end else p += 1;
      end
      gap = 1'b0;
      for (int q = 0; q < N; q++) begin
        if (v[q] == '0) gap = 1'b1;
        else if (gap) rdy = 1'b0;
        line_coord(d, k, q, r, c);
        o[r][c] = v[q];
      end
    end
    return o;
  endfunction

  // Compaction: tiles keep their order and close up toward the front.
  // Steps: the t-th tile needs its distance d_t, but cannot finish earlier
  // than one cycle after the tile in front of it (if it has to move at all).
  function automatic board_t compact(input board_t b, input logic [3:0] d, output int steps);
    board_t       o;
    logic [W-1:0] v;
    int           r, c, q, f, fprev;
    o = '0;
    steps = 0;
    for (int k = 0; k < N; k++) begin
      q = 0;
      fprev = 0;
      for (int p = 0; p < N; p++) begin
        line_coord(d, k, p, r, c);
        v = b[r][c];
        if (v != '0) begin
          if (p > q) f = ((p - q) > fprev + 1) ? (p - q) : fprev + 1;
          else       f = 0;
          fprev = f;
          if (f > steps) steps = f;
          line_coord(d, k, q, r, c);
          o[r][c] = v;
          q++;
        end
      end
    end
    return o;
  endfunction

  always_comb begin
    bit r;
    summed_i    = sum_model(sum_board_o, sum_dir_o, r);
    sum_ready_i = r;
  end

  task automatic check(input string tag, input logic [N*N*W-1:0] obs, input logic [N*N*W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic board_t rand_board();
    board_t b;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        b[i][j] = ($urandom_range(0, 1) == 0) ? '0 : (W'(1) << $urandom_range(1, 3));
    return b;
  endfunction

  // Drive one accepted move and check latency, result, moved flag and that
  // the engine stays busy until a single done pulse.
  task automatic run_move(input string tag, input board_t b, input logic [3:0] d, input bit hold,
                          input board_t exp_b, input int exp_lat, input bit exp_moved);
    int lat;
    bit busy_ok;
    @(negedge clk);
    board_i    = b;
    direction  = d;
    move_valid = 1'b1;
    check({tag, "_ready"}, move_ready, 1);
    @(posedge clk); #1;
    board_i = rand_board();
    if (!hold) move_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 20) begin
      if (move_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    move_valid = 1'b0;
    check({tag, "_busy"}, busy_ok, 1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_board"}, board_o, exp_b);
    check({tag, "_moved"}, moved, exp_moved);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_moved_held"}, moved, exp_moved);
    if (hold) begin
      repeat (3) begin
        @(posedge clk); #1;
        check({tag, "_single_done"}, done, 0);
      end
    end
  endtask

  initial begin
    board_t b, e, c1, sm;
    int     s1, s2, nd;
    bit     rdy;
    logic [3:0] d;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_board_o", board_o, '0);
    check("rst_sum_dir", sum_dir_o, 0);
    check("rst_done", done, 0);
    check("rst_moved", moved, 0);
    check("rst_ready", move_ready, 1);
    rst_n = 1'b1;

    // Reset in the middle of SHIFT1 aborts the move
    b = '0; b[3][0] = W'(2);
    @(negedge clk);
    board_i = b; direction = DIR_DOWN; move_valid = 1'b1;
    @(posedge clk); #1;
    move_valid = 1'b0;
    check("abort_busy", move_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_board_o", board_o, '0);
    check("abort_sum_dir", sum_dir_o, 0);
    check("abort_done", done, 0);
    check("abort_moved", moved, 0);
    check("abort_ready", move_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done === 1'b1) nd++;
    end
    check("abort_no_done", nd, 0);

    // Down: single tile falls three rows
    b = '0; b[3][0] = W'(2);
    e = '0; e[0][0] = W'(2);
    run_move("down3", b, DIR_DOWN, 1'b0, e, 6, 1'b1);

    // Left (front = column 3): 2,2,4,0 -> sum 4,0,4,0 -> 4,4,0,0, no double merge
    b = '0; b[0][3] = W'(2); b[0][2] = W'(2); b[0][1] = W'(4);
    e = '0; e[0][3] = W'(4); e[0][2] = W'(4);
    run_move("left_merge", b, DIR_LEFT, 1'b0, e, 5, 1'b1);

    // Up (front = row 3): already settled, nothing changes
    b = '0; b[3][2] = W'(4);
    run_move("up_settled", b, DIR_UP, 1'b0, b, 3, 1'b0);

    // Non-one-hot direction is ignored
    @(negedge clk);
    board_i = rand_board(); direction = 4'b0110; move_valid = 1'b1;
    nd = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done === 1'b1 || move_ready !== 1'b1) nd++;
    end
    move_valid = 1'b0;
    check("bad_dir_ignored", nd, 0);

    // Right (front = column 0): full row without merges, valid held high
    b = '0; b[1][0] = W'(2); b[1][1] = W'(4); b[1][2] = W'(8); b[1][3] = W'(16);
    run_move("right_full", b, DIR_RIGHT, 1'b1, b, 3, 1'b0);

    // Random moves against the reference
    for (int t = 0; t < 40; t++) begin
      b  = rand_board();
      d  = 4'b0001 << $urandom_range(0, 3);
      c1 = compact(b, d, s1);
      sm = sum_model(c1, d, rdy);
      if (rdy) begin
        e  = sm;
        s2 = 0;
      end else e = compact(sm, d, s2);
      run_move($sformatf("rand%0d", t), b, d, 1'($urandom_range(0, 1)), e,
               rdy ? 3 + s1 : 4 + s1 + s2, e != b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
